// File: rtl/complex_lane_demux.sv
// complex_lane_demux
//   Collects LANES consecutive accepted Re/Im samples from a serial stream and
//   presents them as one parallel word. Idle cycles do not break a group,
//   in_sop realigns to lane 0, and in_last flushes a partial group together
//   with a lane mask that shows which lanes hold real samples.
//
// Parameters
//   bit_width : width of each Re/Im sample (signed two's complement)
//   LANES     : samples per output group (power of two, 2..16)
//   LW        : lane counter width, derived from LANES (leave at default)
//
// Ports
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   Re_i, Im_i      : input sample
//   in_valid        : sample present this cycle
//   in_sop, in_last : frame start / frame end, qualified by in_valid
//   Re_o, Im_o      : grouped samples, lane k at [k*bit_width +: bit_width]
//   lane_mask       : bit k set when lane k holds a real sample
//   out_valid       : one-cycle pulse per presented group
//   out_last        : group was closed by in_last
//   err_align       : one-cycle pulse when in_sop drops a partial group
module complex_lane_demux #(
    parameter int bit_width = 16,
    parameter int LANES     = 4,
    parameter int LW        = $clog2(LANES)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [bit_width-1:0]   Re_i,
    input  logic signed [bit_width-1:0]   Im_i,
    input  logic                          in_valid,
    input  logic                          in_sop,
    input  logic                          in_last,
    output logic [LANES*bit_width-1:0]    Re_o,
    output logic [LANES*bit_width-1:0]    Im_o,
    output logic [LANES-1:0]              lane_mask,
    output logic                          out_valid,
    output logic                          out_last,
    output logic                          err_align
);

    logic [LW-1:0]              r_lane;
    logic [bit_width-1:0]       r_stg_re [LANES];
    logic [bit_width-1:0]       r_stg_im [LANES];

    logic [LW-1:0]              w_lane_eff;
    logic                       w_close;
    logic [LANES*bit_width-1:0] w_grp_re;
    logic [LANES*bit_width-1:0] w_grp_im;
    logic [LANES-1:0]           w_grp_mask;

    // Lane the current sample lands in: in_sop forces realignment to lane 0.
    // The closing sample bypasses staging so the group appears one cycle later.
    always_comb begin
        w_lane_eff = in_sop ? '0 : r_lane;
        w_close    = in_valid && ((w_lane_eff == LW'(LANES - 1)) || in_last);
        w_grp_re   = '0;
        w_grp_im   = '0;
        w_grp_mask = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (LW'(k) < w_lane_eff) begin
                w_grp_re[k*bit_width +: bit_width] = r_stg_re[k];
                w_grp_im[k*bit_width +: bit_width] = r_stg_im[k];
                w_grp_mask[k]                      = 1'b1;
            end else if (LW'(k) == w_lane_eff) begin
                w_grp_re[k*bit_width +: bit_width] = Re_i;
                w_grp_im[k*bit_width +: bit_width] = Im_i;
                w_grp_mask[k]                      = 1'b1;
            end
        end
    end

    // A partial group dropped by in_sop is never cleared from staging: lanes
    // above the closing lane are masked to zero when the next group closes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane    <= '0;
            for (int unsigned k = 0; k < LANES; k++) begin
                r_stg_re[k] <= '0;
                r_stg_im[k] <= '0;
            end
            Re_o      <= '0;
            Im_o      <= '0;
            lane_mask <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            err_align <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            err_align <= in_valid && in_sop && (r_lane != '0);
            if (in_valid) begin
                if (w_close) begin
                    Re_o      <= w_grp_re;
                    Im_o      <= w_grp_im;
                    lane_mask <= w_grp_mask;
                    out_valid <= 1'b1;
                    out_last  <= in_last;
                    r_lane    <= '0;
                end else begin
                    r_stg_re[w_lane_eff] <= Re_i;
                    r_stg_im[w_lane_eff] <= Im_i;
                    r_lane               <= w_lane_eff + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_complex_lane_demux.sv
// Bench for complex_lane_demux at default parameters (bit_width=16, LANES=4).
// A queue-based reference model tracks the samples of the open group and
// predicts every output each cycle; directed table rows carry their own
// hand-derived expectations in addition.
module tb_complex_lane_demux;

    localparam int W     = 16;
    localparam int LANES = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [W-1:0]         Re_i, Im_i;
    logic                 in_valid, in_sop, in_last;
    logic [LANES*W-1:0]   Re_o, Im_o;
    logic [LANES-1:0]     lane_mask;
    logic                 out_valid, out_last, err_align;

    complex_lane_demux #(.bit_width(W), .LANES(LANES)) dut (
        .clk(clk), .rst_n(rst_n),
        .Re_i(Re_i), .Im_i(Im_i),
        .in_valid(in_valid), .in_sop(in_sop), .in_last(in_last),
        .Re_o(Re_o), .Im_o(Im_o), .lane_mask(lane_mask),
        .out_valid(out_valid), .out_last(out_last), .err_align(err_align)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    logic [W-1:0]       q_re[$];
    logic [W-1:0]       q_im[$];
    logic [LANES*W-1:0] m_re, m_im;
    logic [LANES-1:0]   m_mask;
    logic               m_valid, m_last, m_err;

    task automatic model_reset();
        q_re.delete(); q_im.delete();
        m_re = '0; m_im = '0; m_mask = '0;
        m_valid = 1'b0; m_last = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic s, input logic l,
                              input logic [W-1:0] re, input logic [W-1:0] im);
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (v) begin
            if (s) begin
                if (q_re.size() != 0) m_err = 1'b1;
                q_re.delete(); q_im.delete();
            end
            q_re.push_back(re);
            q_im.push_back(im);
            if (q_re.size() == LANES || l) begin
                m_re = '0; m_im = '0;
                foreach (q_re[i]) begin
                    m_re[i*W +: W] = q_re[i];
                    m_im[i*W +: W] = q_im[i];
                end
                m_mask  = LANES'((1 << q_re.size()) - 1);
                m_valid = 1'b1;
                m_last  = l;
                q_re.delete(); q_im.delete();
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("err_align", 64'(err_align), 64'(m_err));
        chk("out_last",  64'(out_last),  64'(m_last));
        chk("lane_mask", 64'(lane_mask), 64'(m_mask));
        chk("Re_o",      64'(Re_o),      64'(m_re));
        chk("Im_o",      64'(Im_o),      64'(m_im));
    endtask

    // One clock: drive after the falling edge, sample 1 time unit after the rising edge.
    task automatic cycle(input logic v, input logic s, input logic l,
                         input logic [W-1:0] re, input logic [W-1:0] im);
        @(negedge clk);
        in_valid = v; in_sop = s; in_last = l; Re_i = re; Im_i = im;
        model_step(v, s, l, re, im);
        @(posedge clk);
        #1;
        check_model();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        v, s, l;
        logic [15:0] re, im;
        logic        e_valid, e_err, e_last;
        logic [3:0]  e_mask;
        logic [63:0] e_re;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input logic v, input logic s, input logic l, input logic [15:0] re,
                       input logic ev, input logic ee, input logic el,
                       input logic [3:0] em, input logic [63:0] ere);
        vec_t r;
        r.v = v; r.s = s; r.l = l; r.re = re; r.im = 16'(-re);
        r.e_valid = ev; r.e_err = ee; r.e_last = el; r.e_mask = em; r.e_re = ere;
        tbl.push_back(r);
    endtask

    initial begin
        logic [63:0] g1, g2, g3, g4;
        g1 = 64'h0004_0003_0002_0001;
        g2 = 64'h0008_0007_0006_0005;
        g3 = 64'h0000_0000_0006_0005;
        g4 = 64'h000F_000E_000D_000C;

        // continuous stream 1..8
        row(1,1,0,16'd1, 0,0,0,4'h0,64'h0);
        row(1,0,0,16'd2, 0,0,0,4'h0,64'h0);
        row(1,0,0,16'd3, 0,0,0,4'h0,64'h0);
        row(1,0,0,16'd4, 1,0,0,4'hF,g1);
        row(1,0,0,16'd5, 0,0,0,4'hF,g1);
        row(1,0,0,16'd6, 0,0,0,4'hF,g1);
        row(1,0,0,16'd7, 0,0,0,4'hF,g1);
        row(1,0,0,16'd8, 1,0,0,4'hF,g2);
        // same data with gaps: grouping survives idle cycles
        row(1,0,0,16'd1, 0,0,0,4'hF,g2);
        row(0,0,0,16'd0, 0,0,0,4'hF,g2);
        row(1,0,0,16'd2, 0,0,0,4'hF,g2);
        row(0,0,0,16'd0, 0,0,0,4'hF,g2);
        row(1,0,0,16'd3, 0,0,0,4'hF,g2);
        row(0,0,0,16'd0, 0,0,0,4'hF,g2);
        row(1,0,0,16'd4, 1,0,0,4'hF,g1);
        row(0,0,0,16'd0, 0,0,0,4'hF,g1);
        // 6-sample frame: second group flushed partial by in_last
        row(1,1,0,16'd1, 0,0,0,4'hF,g1);
        row(1,0,0,16'd2, 0,0,0,4'hF,g1);
        row(1,0,0,16'd3, 0,0,0,4'hF,g1);
        row(1,0,0,16'd4, 1,0,0,4'hF,g1);
        row(1,0,0,16'd5, 0,0,0,4'hF,g1);
        row(1,0,1,16'd6, 1,0,1,4'h3,g3);
        // in_sop on the 3rd sample drops 10,11
        row(1,1,0,16'd10, 0,0,1,4'h3,g3);
        row(1,0,0,16'd11, 0,0,1,4'h3,g3);
        row(1,1,0,16'd12, 0,1,1,4'h3,g3);
        row(1,0,0,16'd13, 0,0,1,4'h3,g3);
        row(0,1,1,16'd99, 0,0,1,4'h3,g3);  // sop/last without valid: ignored
        row(1,0,0,16'd14, 0,0,1,4'h3,g3);
        row(1,0,0,16'd15, 1,0,0,4'hF,g4);
        // sop+last while a partial group is staged: both pulses
        row(1,1,0,16'd20, 0,0,0,4'hF,g4);
        row(1,0,0,16'd21, 0,0,0,4'hF,g4);
        row(1,1,1,16'd22, 1,1,1,4'h1,64'h0000_0000_0000_0016);

        rst_n = 1'b0; in_valid = 0; in_sop = 0; in_last = 0; Re_i = '0; Im_i = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_model();
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].s, tbl[i].l, tbl[i].re, tbl[i].im);
            chk("tbl_valid", 64'(out_valid), 64'(tbl[i].e_valid));
            chk("tbl_err",   64'(err_align), 64'(tbl[i].e_err));
            chk("tbl_last",  64'(out_last),  64'(tbl[i].e_last));
            chk("tbl_mask",  64'(lane_mask), 64'(tbl[i].e_mask));
            chk("tbl_re",    64'(Re_o),      tbl[i].e_re);
        end

        // single-sample frame with extreme values
        cycle(1, 1, 1, 16'h7FFF, 16'h8000);
        chk("extreme_re",   64'(Re_o),      64'h0000_0000_0000_7FFF);
        chk("extreme_im",   64'(Im_o),      64'h0000_0000_0000_8000);
        chk("extreme_mask", 64'(lane_mask), 64'h1);
        chk("extreme_last", 64'(out_last),  64'h1);

        // reset after 2 staged samples; stale data must not reappear
        cycle(1, 0, 0, 16'h00E1, 16'h00F1);
        cycle(1, 0, 0, 16'h00E2, 16'h00F2);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 0; in_sop = 0; in_last = 0;
        #1;
        model_reset();
        check_model();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 0, 0, 16'h00A1, 16'h00B1);
        cycle(1, 0, 0, 16'h00A2, 16'h00B2);
        cycle(1, 0, 0, 16'h00A3, 16'h00B3);
        cycle(1, 0, 0, 16'h00A4, 16'h00B4);
        chk("post_reset_valid", 64'(out_valid), 64'h1);
        chk("post_reset_re",    64'(Re_o),      64'h00A4_00A3_00A2_00A1);
        chk("post_reset_mask",  64'(lane_mask), 64'hF);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) == 0), W'($urandom), W'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/complex_lane_demux.md
# complex_lane_demux

Parametrised 1-to-LANES demultiplexer for complex sample streams. Collects LANES consecutive valid Re/Im samples from a serial stream and presents them together as one parallel word, feeding the radix-2/radix-4 butterfly stages of the FFT sequencer. Successor to the fixed 2-way demultiplexor, with these additions: configurable lane count, gap-tolerant grouping, explicit start-of-frame realignment, and end-of-frame flush of partial groups with a lane mask.

## Interface
- bit_width, 16: width of each Re/Im sample (signed two's complement).
- LANES, 4: samples per output group; power of two, 2..16.
- LW, $clog2(LANES): width of the internal lane counter (derived; do not override).

- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  reset; asynchronous, active-low.
- Re_i  in  bit_width  real part of input sample (signed).
- Im_i  in  bit_width  imaginary part of input sample (signed).
- in_valid  in  1  sample present this cycle.
- in_sop  in  1  start of frame; qualified by in_valid.
- in_last  in  1  last sample of frame; qualified by in_valid.
- Re_o  out  LANES*bit_width  real parts; lane k at bits [k*bit_width +: bit_width].
- Im_o  out  LANES*bit_width  imaginary parts, same packing.
- lane_mask  out  LANES  bit k = lane k holds a real sample.
- out_valid  out  1  one-cycle pulse; group presented.
- out_last  out  1  group closed by in_last; valid with out_valid.
- err_align  out  1  one-cycle pulse; partial group discarded by in_sop.

## Operation
- Lane counter `lane` (LW bits) and staging registers, one per lane. Sample accepted when in_valid=1.
- Accepted sample is written to staging lane `lane`. Group order: first-arriving sample goes to lane 0 (LSBs).
- Gaps (in_valid=0) never reset `lane`. Unlike the 2-way block, grouping survives idle cycles.
- Group close: an accepted sample closes the group when `lane`==LANES-1 or in_last=1. Next cycle:
  - Re_o/Im_o are loaded from staging, with the closing sample taking its lane directly (no extra cycle).
  - lane_mask = bits [0..lane] set.
  - Lanes above the closing lane are driven to 0.
  - out_valid=1 and out_last=in_last. `lane` returns to 0.
- in_sop with in_valid: the sample is forced to lane 0.
  - If `lane`≠0 at that time, the staged partial group is dropped (no output) and err_align pulses for 1 cycle.
  - If `lane`==0, there is no error.
- in_sop and in_last in the same cycle: single-sample group; lane_mask=1, out_last=1.
- in_sop/in_last with in_valid=0 are ignored.
- Outputs Re_o, Im_o, lane_mask and out_last hold their value until the next group closes. out_valid is high for exactly 1 cycle per group.
- Arithmetic: none. Samples are passed bit-exact; no sign extension or rounding.
- No backpressure. The consumer must accept at up to one group per LANES accepted samples. A full-rate stream produces out_valid every LANES cycles.

## Timing
- Reset values:
  - Re_o=0, Im_o=0, lane_mask=0, out_valid=0, out_last=0, err_align=0.
  - lane=0, staging=0.
- Latency: 1 cycle from the closing sample's in_valid edge to out_valid.
- Throughput: 1 sample/cycle sustained. Back-to-back groups are supported (closing sample at cycle t, next group's lane 0 sample at t+1).
- Reset mid-group: all staged data is discarded. The first sample after reset release lands in lane 0.
- Simultaneous events:
  - in_sop on a full-group boundary (`lane`==0): normal operation.
  - in_sop while a group is outstanding on the outputs: no effect on the held outputs.
  - err_align and out_valid cannot pulse in the same cycle from the same sample, except with in_sop+in_last while `lane`≠0. In that case both pulse: the old partial group is dropped and the single-sample group is emitted.

## Test plan
- LANES=4, continuous in_valid, Re_i=1..8, Im_i=-1..-8.
  - out_valid at cycles 5 and 9.
  - Groups: Re_o lanes {1,2,3,4}, then {5,6,7,8}; Im_o negated; lane_mask=4'b1111; out_last=0.
- Same data with in_valid toggling 1,0,1,0.
  - Identical groups; each out_valid 1 cycle after the 4th/8th accepted sample.
- Frame of 6 samples (in_last on sample 6).
  - Second group: lanes {5,6,0,0}, lane_mask=4'b0011, out_last=1.
- in_sop on the 3rd sample of a group (values 10,11,12,...).
  - err_align pulses 1 cycle; no output for 10,11.
  - Next group starts with 12 in lane 0.
- in_sop+in_last on a single sample 0x7FFF/0x8000.
  - Re_o lane0=0x7FFF, Im_o lane0=0x8000, lane_mask=4'b0001, out_last=1.
- Assert rst_n low after 2 samples; release, then send 4 samples A..D.
  - All outputs 0 during reset.
  - Single group {A,B,C,D}; stale samples absent.
